ram_bist_ctrl: RTL and testbench

Self-checking read/write sequencer that drives the single-port RAM (32x8) in place of the free-running read/write generator. On a start pulse it writes a deterministic pattern to every address, reads every address back, and compares each returned word against the expected value, accounting for the RAM read latency. It reports busy, a one-cycle done pulse, a pass flag, an error count and the address of the first failing word.

---
 rtl/ram_bist_pkg.sv | 20 ++
 rtl/ram_bist_cmp.sv | 84 ++++++++
 rtl/ram_bist_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM built-in self-test sequencer.
// The pattern function is also used by anything that needs to predict RAM contents.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } bist_state_e;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // Pattern word for an address: seed XOR zero-extended address; callers truncate.
    function automatic logic [31:0] exp_data(input logic [31:0] seed, input logic [31:0] addr);
        return seed ^ addr;
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker: delays {valid, addr} of each issued read by the RAM latency,
// compares returned data with the pattern, counts mismatches and keeps the first failing address.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 5,
    parameter int                RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              done_clear_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [ADDR_W:0]   err_cnt_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    logic [RD_LAT-1:0]             vld_q, vld_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] pipe_q, pipe_d;
    logic [ADDR_W:0]               err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]             err_addr_q, err_addr_d;
    logic [ADDR_W-1:0]             head_addr;
    logic                          head_vld;
    logic [31:0]                   exp_full;
    logic                          mismatch;

    always_comb begin
        head_addr = pipe_q[RD_LAT-1];
        head_vld  = vld_q[RD_LAT-1];
        exp_full  = exp_data(32'(SEED), 32'(head_addr));
        mismatch  = head_vld && (rd_data_i != exp_full[DATA_W-1:0]);
    end

    always_comb begin
        vld_d  = vld_q;
        pipe_d = pipe_q;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_d[i]  = vld_q[i-1];
            pipe_d[i] = pipe_q[i-1];
        end
        vld_d[0]  = rd_en_i;
        pipe_d[0] = rd_addr_i;
        if (clear_i || done_clear_i) begin
            vld_d = '0;
        end

        // The counter saturates; the first-error address is captured only while the count is still zero.
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (clear_i) begin
            err_cnt_d  = '0;
            err_addr_d = '0;
        end else if (mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + (ADDR_W + 1)'(1);
            end
            if (err_cnt_q == '0) begin
                err_addr_d = head_addr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q      <= '0;
            pipe_q     <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            vld_q      <= vld_d;
            pipe_q     <= pipe_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// BIST sequencer for a single-port RAM: writes the pattern to every word, reads it all
// back through the latency-matched checker and reports busy/done/pass and error details.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 5,
    parameter int                DEPTH  = 32,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED),
    parameter int                RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              ram_wr_en_o,
    output logic              ram_rd_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wr_data_o,
    input  logic [DATA_W-1:0] ram_rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W:0]   err_cnt_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [1:0]        drain_q, drain_d;
    logic              cmp_clear;
    logic              cmp_done_clear;
    logic [ADDR_W:0]   err_cnt;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = exp_data(32'(SEED), 32'(a));
        return t[DATA_W-1:0];
    endfunction

    // READ spends its first cycle with rd_en low, which gives the single idle cycle after WRITE.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wr_en_d        = 1'b0;
        rd_en_d        = 1'b0;
        wr_data_d      = '0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        drain_d        = drain_q;
        cmp_clear      = 1'b0;
        cmp_done_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = WRITE;
                    addr_d    = '0;
                    wr_en_d   = 1'b1;
                    wr_data_d = pattern('0);
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    cmp_clear = 1'b1;
                end
            end
            WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = READ;
                    addr_d  = '0;
                end else begin
                    addr_d    = addr_q + ADDR_W'(1);
                    wr_en_d   = 1'b1;
                    wr_data_d = pattern(addr_q + ADDR_W'(1));
                end
            end
            READ: begin
                if (!rd_en_q) begin
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: begin
                state_d        = IDLE;
                done_d         = 1'b1;
                busy_d         = 1'b0;
                pass_d         = (err_cnt == '0);
                cmp_done_clear = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            drain_q   <= drain_d;
        end
    end

    ram_bist_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .SEED   (SEED)
    ) u_cmp (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (cmp_clear),
        .done_clear_i (cmp_done_clear),
        .rd_en_i      (rd_en_q),
        .rd_addr_i    (addr_q),
        .rd_data_i    (ram_rd_data_i),
        .err_cnt_o    (err_cnt),
        .err_addr_o   (err_addr_o)
    );

    assign ram_wr_en_o   = wr_en_q;
    assign ram_rd_en_o   = rd_en_q;
    assign ram_addr_o    = addr_q;
    assign ram_wr_data_o = wr_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign err_cnt_o     = err_cnt;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: lane 0 uses RD_LAT=1, lane 1 uses RD_LAT=3,
// each with a behavioural RAM that can inject read faults.
module tb_ram_bist_ctrl;

    logic       clock = 1'b0;
    logic       rstN;
    logic       start   [2];
    logic       wrEn    [2];
    logic       rdEn    [2];
    logic [4:0] addr    [2];
    logic [7:0] wrData  [2];
    logic [7:0] rdData  [2];
    logic       busy    [2];
    logic       done    [2];
    logic       pass    [2];
    logic [5:0] errCnt  [2];
    logic [4:0] errAddr [2];

    int nVectors     = 0;
    int nMiscompares = 0;
    int cycle        = 0;
    int faultMode    = 0;
    int wrCnt        = 0;
    int rdCnt        = 0;
    int doneCnt      = 0;
    int overlapCnt   = 0;
    int lastWrCyc    = 0;
    int rdGap        = 0;
    logic prevRd     = 1'b0;

    logic [12:0] wrQ  [$];
    logic [31:0] resQ [$];

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [7:0] ramReturn(input int mode, input logic [4:0] a, input logic [7:0] v);
        case (mode)
            1:       return (a == 5'd4 || a == 5'd9) ? (v | 8'h01) : v;
            2:       return (a == 5'd4) ? 8'h00 : ((a == 5'd9) ? (v | 8'h01) : v);
            3:       return 8'h00;
            default: return v;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gLane
        localparam int L = (g == 0) ? 1 : 3;
        logic [7:0] mem [32];
        logic [7:0] qs  [3];

        ram_bist_ctrl #(
            .DATA_W (8),
            .ADDR_W (5),
            .DEPTH  (32),
            .SEED   (8'hA5),
            .RD_LAT (L)
        ) uDut (
            .clk_i         (clock),
            .rst_ni        (rstN),
            .start_i       (start[g]),
            .ram_wr_en_o   (wrEn[g]),
            .ram_rd_en_o   (rdEn[g]),
            .ram_addr_o    (addr[g]),
            .ram_wr_data_o (wrData[g]),
            .ram_rd_data_i (rdData[g]),
            .busy_o        (busy[g]),
            .done_o        (done[g]),
            .pass_o        (pass[g]),
            .err_cnt_o     (errCnt[g]),
            .err_addr_o    (errAddr[g])
        );

        // Single-port RAM whose q appears L edges after the read is sampled.
        always @(posedge clock) begin
            if (wrEn[g]) mem[addr[g]] <= wrData[g];
            if (rdEn[g]) qs[0] <= ramReturn(faultMode, addr[g], mem[addr[g]]);
            qs[1] <= qs[0];
            qs[2] <= qs[1];
        end

        assign rdData[g] = qs[L-1];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        nVectors++;
        if (got !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
        end
    endtask

    function automatic logic [31:0] packLane(input int lane);
        return {3'b0, wrEn[lane], rdEn[lane], addr[lane], wrData[lane], busy[lane],
                done[lane], pass[lane], errCnt[lane], errAddr[lane]};
    endfunction

    function automatic logic [31:0] predictResult(input int mode);
        int         cnt   = 0;
        logic [4:0] first = 5'd0;
        logic [7:0] e;
        logic [7:0] r;
        for (int a = 0; a < 32; a++) begin
            e = 8'hA5 ^ 8'(a);
            r = ramReturn(mode, 5'(a), e);
            if (r != e) begin
                if (cnt == 0) first = 5'(a);
                cnt++;
            end
        end
        return {20'b0, (cnt == 0), 6'(cnt), first};
    endfunction

    // Lane 0 write stream is scored against the expected pattern as it leaves the DUT.
    always @(negedge clock) begin
        logic [12:0] e;
        if (wrEn[0]) begin
            wrCnt++;
            lastWrCyc = cycle;
            if (wrQ.size() == 0) begin
                checkOutput("wr_extra", 32'(wrEn[0]), 32'd0);
            end else begin
                e = wrQ.pop_front();
                checkOutput("wr_addr", 32'(addr[0]), 32'(e[12:8]));
                checkOutput("wr_data", 32'(wrData[0]), 32'(e[7:0]));
            end
        end
        if (rdEn[0]) begin
            rdCnt++;
            if (!prevRd) rdGap = cycle - lastWrCyc;
        end
        if (wrEn[0] && rdEn[0]) overlapCnt++;
        if (done[0]) doneCnt++;
        prevRd = rdEn[0];
    end

    task automatic pushWrites();
        for (int a = 0; a < 32; a++) wrQ.push_back({5'(a), 8'hA5 ^ 8'(a)});
    endtask

    task automatic applyStimulus(input int lane, input int mode, input bit extraStarts);
        int          startCyc;
        int          doneCyc = 0;
        int          w0;
        int          r0;
        int          d0;
        int          o0;
        int          rel;
        bit          got = 1'b0;
        logic [31:0] r;
        int          lat = (lane == 0) ? 1 : 3;

        if (lane == 0) pushWrites();
        resQ.push_back(predictResult(mode));
        faultMode = mode;
        w0 = wrCnt; r0 = rdCnt; d0 = doneCnt; o0 = overlapCnt;

        @(negedge clock);
        start[lane] = 1'b1;
        @(posedge clock);
        #1 startCyc = cycle;
        @(negedge clock);
        start[lane] = 1'b0;
        checkOutput("busy_run", 32'(busy[lane]), 32'd1);
        checkOutput("start_clear", {26'b0, pass[lane], errCnt[lane][4:0]} | 32'(errAddr[lane]), 32'd0);

        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            rel = cycle - startCyc;
            if (done[lane]) begin
                got          = 1'b1;
                doneCyc      = cycle;
                start[lane]  = 1'b0;
            end else if (extraStarts) begin
                start[lane] = (rel == 4 || rel == 39 || rel == 65 || rel == 66);
            end
        end

        if (!got) begin
            checkOutput("done_timeout", 32'(done[lane]), 32'd1);
        end else begin
            r = resQ.pop_front();
            checkOutput("latency", 32'(doneCyc - startCyc), 32'(2 * 32 + lat + 2));
            checkOutput("res_pass", 32'(pass[lane]), 32'(r[11]));
            checkOutput("res_errcnt", 32'(errCnt[lane]), 32'(r[10:5]));
            checkOutput("res_erraddr", 32'(errAddr[lane]), 32'(r[4:0]));
            checkOutput("done_busy", 32'(busy[lane]), 32'd0);
            checkOutput("post_addr", {26'b0, rdEn[lane], addr[lane]}, 32'd0);
            @(negedge clock);
            checkOutput("done_pulse", 32'(done[lane]), 32'd0);
            repeat (6) @(negedge clock);
            checkOutput("pass_held", 32'(pass[lane]), 32'(r[11]));
            checkOutput("no_restart", 32'(busy[lane]), 32'd0);
            if (lane == 0) begin
                checkOutput("wr_count", 32'(wrCnt - w0), 32'd32);
                checkOutput("rd_count", 32'(rdCnt - r0), 32'd32);
                checkOutput("done_count", 32'(doneCnt - d0), 32'd1);
                checkOutput("wr_rd_gap", 32'(rdGap), 32'd2);
                checkOutput("wr_rd_overlap", 32'(overlapCnt - o0), 32'd0);
                checkOutput("wr_leftover", 32'(wrQ.size()), 32'd0);
            end
        end
        resQ.delete();
        wrQ.delete();
    endtask

    initial begin
        int  w0;
        int  r0;
        int  d0;
        bit  found = 1'b0;

        rstN     = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_lane0", packLane(0), 32'd0);
        checkOutput("reset_lane1", packLane(1), 32'd0);
        rstN = 1'b1;

        w0 = wrCnt; r0 = rdCnt;
        repeat (10) @(negedge clock);
        checkOutput("idle_wr", 32'(wrCnt - w0), 32'd0);
        checkOutput("idle_rd", 32'(rdCnt - r0), 32'd0);
        checkOutput("idle_outputs", packLane(0), 32'd0);

        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 1, 1'b0);
        applyStimulus(0, 2, 1'b0);
        applyStimulus(0, 3, 1'b0);
        applyStimulus(1, 3, 1'b0);
        applyStimulus(0, 0, 1'b1);

        // Abort a pass with reset in the middle of the read phase.
        pushWrites();
        faultMode = 0;
        @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (rdEn[0] && addr[0] == 5'd12) found = 1'b1;
        end
        checkOutput("abort_reach", 32'(found), 32'd1);
        d0   = doneCnt;
        rstN = 1'b0;
        #1;
        checkOutput("abort_reset", packLane(0), 32'd0);
        repeat (4) @(negedge clock);
        checkOutput("abort_nodone", 32'(doneCnt - d0), 32'd0);
        rstN = 1'b1;
        wrQ.delete();
        applyStimulus(0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
